// File: rtl/spi_controller_if.sv
// Request/status handshake plus SPI pins of spi_controller.
// The requester uses modport master; the controller uses modport slave.
interface spi_controller_if;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic       err;
    logic       SCLK;
    logic       COPI;
    logic       nCS;

    modport master (
        output start, rw, addr, wdata,
        input  busy, done, err, SCLK, COPI, nCS
    );

    modport slave (
        input  start, rw, addr, wdata,
        output busy, done, err, SCLK, COPI, nCS
    );
endinterface

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: sends one 16-bit {rw, addr, wdata} frame per start, MSB first.
// Optional macro ADDR_CHECK_EN rejects addresses above MAX_ADDR with an err/done pulse.
//
// state | meaning
// IDLE  | bus idle, waiting for start
// LEAD  | nCS low, COPI = bit 15, setup time before first SCLK rise
// SHIFT | 16 bits, SCLK high half then low half each
// TRAIL | nCS still low, COPI holds bit 0, hold time
// GAP   | nCS high; done on the last cycle
module spi_controller #(
    parameter int CLK_DIV = 4
`ifdef ADDR_CHECK_EN
    , parameter int MAX_ADDR = 4
`endif
) (
    input  logic           clk,
    input  logic           rst,
    spi_controller_if.slave bus
);
    localparam int         CW     = $clog2(CLK_DIV);
    localparam logic [CW-1:0] DIV_M1 = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic [3:0]     bit_cnt, bit_nx;
    logic           sclk_hi, hi_nx;
    logic [15:0]    shreg, shreg_nx;
    logic           fin, err_nx, done_nx, in_frame;
    logic           reject;
    logic           busy_q, done_q, err_q, sclk_q, copi_q, ncs_q;

`ifdef ADDR_CHECK_EN
    localparam logic [6:0] MAX_A = 7'(MAX_ADDR);
    assign reject = (bus.addr > MAX_A);
`else
    assign reject = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        bit_nx   = bit_cnt;
        hi_nx    = sclk_hi;
        shreg_nx = shreg;
        fin      = 1'b0;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (reject) begin
                        err_nx = 1'b1;
                        fin    = 1'b1;
                    end else begin
                        state_nx = LEAD;
                        cnt_nx   = DIV_M1;
                        bit_nx   = 4'd15;
                        hi_nx    = 1'b0;
                        shreg_nx = {bus.rw, bus.addr, bus.wdata};
                    end
                end
            end
            LEAD: begin
                if (cnt == '0) begin
                    state_nx = SHIFT;
                    cnt_nx   = DIV_M1;
                    hi_nx    = 1'b1;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            SHIFT: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                end else begin
                    cnt_nx = DIV_M1;
                    if (sclk_hi) begin
                        // Falling edge: present the next bit, but bit 0 stays through TRAIL
                        hi_nx = 1'b0;
                        if (bit_cnt != 4'd0)
                            shreg_nx = {shreg[14:0], 1'b0};
                    end else if (bit_cnt == 4'd0) begin
                        state_nx = TRAIL;
                    end else begin
                        hi_nx  = 1'b1;
                        bit_nx = bit_cnt - 1'b1;
                    end
                end
            end
            TRAIL: begin
                if (cnt == '0) begin
                    state_nx = GAP;
                    cnt_nx   = DIV_M1;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0)
                    state_nx = IDLE;
                else
                    cnt_nx = cnt - 1'b1;
            end
            default: state_nx = IDLE;
        endcase
        in_frame = (state_nx == LEAD) || (state_nx == SHIFT) || (state_nx == TRAIL);
        done_nx  = fin || ((state_nx == GAP) && (cnt_nx == '0));
    end

    // Outputs are flopped from next-state values so they line up with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            sclk_hi <= 1'b0;
            shreg   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            sclk_q  <= 1'b0;
            copi_q  <= 1'b0;
            ncs_q   <= 1'b1;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_cnt <= bit_nx;
            sclk_hi <= hi_nx;
            shreg   <= shreg_nx;
            busy_q  <= (state_nx != IDLE);
            done_q  <= done_nx;
            err_q   <= err_nx;
            sclk_q  <= (state_nx == SHIFT) && hi_nx;
            copi_q  <= in_frame && shreg_nx[15];
            ncs_q   <= !in_frame;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
    assign bus.SCLK = sclk_q;
    assign bus.COPI = copi_q;
    assign bus.nCS  = ncs_q;
endmodule
